wb_master_arbiter: RTL and testbench
====================================

# wb_master_arbiter

Round-robin Wishbone B4 classic arbiter that shares the single SoC IO master port of the interconnect between several bus masters (core instruction fetch, core load/store, debug/DMA). It sits between the masters and the IO-side input of the address-decoding interconnect. It holds a grant for the whole `cyc` of a transaction. A bus-timeout watchdog converts a hung slave access into an `err` response, so an unmapped address cannot lock up the core.

## Interface
- `num_masters`, default 2: number of requesting masters, range 2..8. Master 0 occupies the lowest slice of every packed vector.
- `TIMEOUT_CYCLES`, default 255: wait cycles before a forced `err`. Range 0..65535; 0 disables the watchdog.
- `wb_clk_i` in 1: bus clock. One clock; everything is sampled on its rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbm_adr_i` in 32*num_masters: master addresses.
- `wbm_dat_i` in 32*num_masters: master write data.
- `wbm_sel_i` in 4*num_masters: byte selects.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in num_masters: master control.
- `wbm_cti_i` in 3*num_masters, `wbm_bte_i` in 2*num_masters: burst tags, passed through.
- `wbm_dat_o` out 32: read data, broadcast to all masters.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out num_masters: per-master responses.
- `wbs_adr_o` out 32, `wbs_dat_o` out 32, `wbs_sel_o` out 4, `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o` out 1, `wbs_cti_o` out 3, `wbs_bte_o` out 2: shared slave-side port to the interconnect.
- `wbs_dat_i` in 32, `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1: interconnect responses.
- `grant_o` out num_masters: one-hot current owner, all zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- **Registered state:** `busy` flag, `owner` index, `last_owner` index, `wait_cnt` (16 bit).
- **Arbitration point:** any cycle where `busy`=0, or where `busy`=1 and `wbm_cyc_i[owner]`=0.
  - If any `wbm_cyc_i` is high, the next owner is the first requester searching upward from `last_owner+1`, wrapping modulo num_masters.
  - On that edge: `busy`←1, `owner`←winner, `last_owner`←winner.
  - With no requester: `busy`←0.
  - The current owner, if it has dropped `cyc`, is skipped. Direct handover between owners costs no idle cycle.
- **While `busy`=1:**
  - All `wbs_*` outputs equal the owner's slice. `wbs_cyc_o`/`wbs_stb_o` are additionally forced to 0 during the timeout cycle.
  - `wbs_ack/err/rty_i` are routed only to `wbm_*_o[owner]`; all other masters see 0.
- **While `busy`=0:** all `wbs_*` outputs are 0 and all master responses are 0.
- A non-owner holding `cyc`/`stb` simply waits; it never receives a response.
- **Watchdog, when `TIMEOUT_CYCLES`≠0:**
  - `wait_cnt` increments on each cycle with owner `stb`=1 and no `wbs_ack_i|wbs_err_i|wbs_rty_i`.
  - It clears on any slave response, when owner `stb`=0, and on every grant change.
  - In the cycle `wait_cnt`==TIMEOUT_CYCLES:
    - `wbm_err_o[owner]`=1 and `timeout_o`=1.
    - `wbs_cyc_o`/`wbs_stb_o`=0.
    - `wait_cnt`←0.
  - Ownership is kept; the owner must drop `stb` or `cyc` after `err`.
- **Simultaneous slave response and timeout:** the slave response wins. The counter clears and no `err` is injected.

## Timing
- **Reset values:** `busy`=0, `owner`=0, `last_owner`=num_masters-1 (master 0 wins first), `wait_cnt`=0. All outputs are 0 in the cycle after the reset edge. Reset asserted mid-transaction aborts it with no response to the master.
- **Grant latency:** a master raising `cyc` in cycle N (bus idle) appears on `wbs_cyc_o` in cycle N+1. Response paths are combinational: slave `ack` in cycle M reaches the owner in cycle M.
- **Handover:** owner drops `cyc` in cycle N while another master requests; the new owner drives `wbs_*` in cycle N+1.
- **Bursts:** the grant is held across consecutive `stb` beats for as long as the owner's `cyc` stays high. The arbiter never preempts.
- **Timeout:** the earliest `err` arrives TIMEOUT_CYCLES+1 cycles after `stb` is first presented with no response.

## Test plan
- **Single master read:** m0 `cyc`/`stb`, adr=0x20000000, slave acks on the 2nd cycle with dat=0xA5A5A5A5. Required: `wbs_cyc_o` rises one cycle after request, m0 gets `ack` with 0xA5A5A5A5, `grant_o`=01, m1 `ack`=0.
- **Contention round-robin:** m0 and m1 request continuously, one word each per `cyc`. Required: grant sequence 0,1,0,1 with zero idle cycles between owners.
- **Burst hold:** m1 holds `cyc` for 4 acked beats (`cti`=010, then 111) while m0 requests. Required: m0 waits all 4 beats and is granted the cycle after m1 drops `cyc`.
- **Timeout:** TIMEOUT_CYCLES=4, m0 accesses 0x50000000 (no slave). Required: m0 `err` and `timeout_o` pulse on the 5th cycle after `stb`, `wbs_stb_o`=0 that cycle, no `ack`.
- **Response/timeout collision:** slave `ack` coincides with `wait_cnt`==TIMEOUT_CYCLES. Required: `ack` delivered, `err`=0, `timeout_o`=0.
- **Reset mid-access:** assert `wb_rst_i` for 1 cycle while m1 owns the bus. Required: all outputs 0 next cycle, and the next contention is won by m0.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module      : wb_master_arbiter
// Description : Round-robin Wishbone B4 classic arbiter that shares one
//               slave-side port among num_masters masters. The grant is held
//               for the whole cyc. A watchdog turns a hung access into err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter #(
  parameter int num_masters    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [32*num_masters-1:0] wbm_adr_i,
  input  logic [32*num_masters-1:0] wbm_dat_i,
  input  logic [4*num_masters-1:0]  wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [3*num_masters-1:0]  wbm_cti_i,
  input  logic [2*num_masters-1:0]  wbm_bte_i,
  output logic [31:0]               wbm_dat_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [num_masters-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int              IDX_W       = $clog2(num_masters);
  localparam bit              WDOG_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0]     TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(num_masters - 1);

  // Registered arbitration and watchdog state
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;

  // Per-master views of the packed input buses
  logic [31:0] w_adr [num_masters];
  logic [31:0] w_dat [num_masters];
  logic [3:0]  w_sel [num_masters];
  logic [2:0]  w_cti [num_masters];
  logic [1:0]  w_bte [num_masters];

  for (genvar g = 0; g < num_masters; g++) begin : g_unpack
    assign w_adr[g] = wbm_adr_i[g*32 +: 32];
    assign w_dat[g] = wbm_dat_i[g*32 +: 32];
    assign w_sel[g] = wbm_sel_i[g*4 +: 4];
    assign w_cti[g] = wbm_cti_i[g*3 +: 3];
    assign w_bte[g] = wbm_bte_i[g*2 +: 2];
  end

  logic             w_resp;
  logic             w_owner_stb;
  logic             w_arb_point;
  logic             w_timeout;
  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_cand;

  assign w_resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_owner_stb = busy_q & wbm_stb_i[owner_q];
  // The bus is free to change hands when idle or once the owner drops cyc
  assign w_arb_point = ~busy_q | ~wbm_cyc_i[owner_q];
  // A real slave response in the same cycle beats the watchdog
  assign w_timeout   = WDOG_EN & w_owner_stb & ~w_resp & (wait_cnt_q == TIMEOUT_VAL);
  assign timeout_o   = w_timeout;

  // Round-robin search: first requester upward from last_owner+1, wrapping
  always_comb begin
    w_found  = 1'b0;
    w_winner = last_owner_q;
    w_cand   = last_owner_q;
    for (int i = 1; i <= num_masters; i++) begin
      if ((int'(last_owner_q) + i) >= num_masters) begin
        w_cand = IDX_W'(int'(last_owner_q) + i - num_masters);
      end else begin
        w_cand = IDX_W'(int'(last_owner_q) + i);
      end
      if (!w_found && wbm_cyc_i[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Next-state for ownership and the watchdog counter
  always_comb begin
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q + 16'd1;
    if (w_arb_point) begin
      if (w_found) begin
        busy_d       = 1'b1;
        owner_d      = w_winner;
        last_owner_d = w_winner;
      end else begin
        busy_d = 1'b0;
      end
    end
    if (!WDOG_EN || w_arb_point || !w_owner_stb || w_resp || w_timeout) begin
      wait_cnt_d = 16'd0;
    end
  end

  // State registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_q       <= 1'b0;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      wait_cnt_q   <= 16'd0;
    end else begin
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Slave-side mux: owner's slice while busy, cyc/stb masked on timeout
  always_comb begin
    wbs_adr_o = 32'd0;
    wbs_dat_o = 32'd0;
    wbs_sel_o = 4'd0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = 3'd0;
    wbs_bte_o = 2'd0;
    if (busy_q) begin
      wbs_adr_o = w_adr[owner_q];
      wbs_dat_o = w_dat[owner_q];
      wbs_sel_o = w_sel[owner_q];
      wbs_we_o  = wbm_we_i[owner_q];
      wbs_cyc_o = wbm_cyc_i[owner_q] & ~w_timeout;
      wbs_stb_o = wbm_stb_i[owner_q] & ~w_timeout;
      wbs_cti_o = w_cti[owner_q];
      wbs_bte_o = w_bte[owner_q];
    end
  end

  // Response routing: only the owner sees ack/err/rty; grant is one-hot
  always_comb begin
    wbm_dat_o = 32'd0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    if (busy_q) begin
      wbm_dat_o          = wbs_dat_i;
      wbm_ack_o[owner_q] = wbs_ack_i;
      wbm_err_o[owner_q] = wbs_err_i | w_timeout;
      wbm_rty_o[owner_q] = wbs_rty_i;
      grant_o[owner_q]   = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// ============================================================================
// Module      : tb_wb_master_arbiter
// Description : Directed self-checking bench for wb_master_arbiter
//               (two masters, watchdog at 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_arbiter;

  localparam int NM = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];
  logic [1:0]  m_we, m_cyc, m_stb;

  logic [63:0] wbm_adr_i, wbm_dat_i;
  logic [7:0]  wbm_sel_i;
  logic [5:0]  wbm_cti_i;
  logic [3:0]  wbm_bte_i;
  assign wbm_adr_i = {m_adr[1], m_adr[0]};
  assign wbm_dat_i = {m_dat[1], m_dat[0]};
  assign wbm_sel_i = {m_sel[1], m_sel[0]};
  assign wbm_cti_i = {m_cti[1], m_cti[0]};
  assign wbm_bte_i = {m_bte[1], m_bte[0]};

  logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
  logic [1:0]  wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  wb_master_arbiter #(.num_masters(NM), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (m_we),      .wbm_cyc_i(m_cyc),     .wbm_stb_i(m_stb),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),  .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),     .wbs_ack_i(s_ack),     .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant_o),   .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic on, input logic [31:0] adr,
                     input logic [2:0] cti, input logic we);
    m_cyc[m] = on;
    m_stb[m] = on;
    m_we[m]  = we;
    m_adr[m] = adr;
    m_dat[m] = ~adr;
    m_sel[m] = on ? 4'hF : 4'h0;
    m_cti[m] = cti;
    m_bte[m] = 2'b00;
  endtask

  initial begin
    logic [1:0]  oh;
    logic [31:0] badr;
    rst = 1'b1;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_cti[m] = '0; m_bte[m] = '0;
    end

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_wbs_cyc", wbs_cyc_o, 1'b0);
    chk("rst_wbs_adr", wbs_adr_o, 32'h0);
    chk("rst_ack", wbm_ack_o, 2'b00);
    chk("rst_err", wbm_err_o, 2'b00);
    chk("rst_timeout", timeout_o, 1'b0);

    // Contention: grants 0,1,0,1 with no idle cycle between owners
    tick();
    req(0, 1'b1, 32'h1000_0000, 3'b000, 1'b0);
    req(1, 1'b1, 32'h1100_0000, 3'b000, 1'b0);
    #1;
    chk("rr_pre_grant", grant_o, 2'b00);
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      s_ack = 1'b1;
      if (k == 1) req(0, 1'b1, 32'h1000_0000, 3'b000, 1'b0);
      if (k == 2) req(1, 1'b1, 32'h1100_0000, 3'b000, 1'b0);
      #1;
      chk("rr_grant", grant_o, oh);
      chk("rr_ack", wbm_ack_o, oh);
      chk("rr_adr", wbs_adr_o, (k % 2 == 0) ? 32'h1000_0000 : 32'h1100_0000);
      tick();
      s_ack = 1'b0;
      req(k % 2, 1'b0, 32'h0, 3'b000, 1'b0);
      #1;
      chk("rr_hold_grant", grant_o, oh);
      chk("rr_drop_cyc", wbs_cyc_o, 1'b0);
    end
    tick(); #1;
    chk("rr_idle", grant_o, 2'b00);

    // Single master read
    tick();
    req(0, 1'b1, 32'h2000_0000, 3'b000, 1'b0);
    #1;
    chk("rd_cyc_pre", wbs_cyc_o, 1'b0);
    tick(); #1;
    chk("rd_cyc", wbs_cyc_o, 1'b1);
    chk("rd_grant", grant_o, 2'b01);
    chk("rd_adr", wbs_adr_o, 32'h2000_0000);
    chk("rd_ack_wait", wbm_ack_o, 2'b00);
    tick();
    s_ack = 1'b1; s_dat = 32'hA5A5_A5A5;
    #1;
    chk("rd_ack", wbm_ack_o, 2'b01);
    chk("rd_dat", wbm_dat_o, 32'hA5A5_A5A5);
    tick();
    s_ack = 1'b0; s_dat = '0;
    req(0, 1'b0, 32'h0, 3'b000, 1'b0);
    tick(); #1;
    chk("rd_idle", grant_o, 2'b00);

    // Burst hold: m1 keeps the bus for 4 beats while m0 waits
    tick();
    req(0, 1'b1, 32'h3000_0000, 3'b000, 1'b0);
    req(1, 1'b1, 32'h4000_0000, 3'b010, 1'b1);
    for (int b = 0; b < 4; b++) begin
      tick();
      badr = 32'h4000_0000 + 32'(4 * b);
      req(1, 1'b1, badr, (b == 3) ? 3'b111 : 3'b010, 1'b1);
      s_ack = 1'b1;
      #1;
      chk("bu_grant", grant_o, 2'b10);
      chk("bu_ack", wbm_ack_o, 2'b10);
      chk("bu_cti", wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
      chk("bu_we", wbs_we_o, 1'b1);
      chk("bu_dat", wbs_dat_o, ~badr);
    end
    tick();
    s_ack = 1'b0;
    req(1, 1'b0, 32'h0, 3'b000, 1'b0);
    #1;
    chk("bu_drop_grant", grant_o, 2'b10);
    tick(); #1;
    chk("bu_handover", grant_o, 2'b01);
    chk("bu_m0_adr", wbs_adr_o, 32'h3000_0000);
    tick();
    s_ack = 1'b1;
    #1;
    chk("bu_m0_ack", wbm_ack_o, 2'b01);
    tick();
    s_ack = 1'b0;
    req(0, 1'b0, 32'h0, 3'b000, 1'b0);
    tick();

    // Timeout: no slave answers 0x50000000
    tick();
    req(0, 1'b1, 32'h5000_0000, 3'b000, 1'b0);
    for (int w = 1; w <= 4; w++) begin
      tick(); #1;
      chk("to_wait_stb", wbs_stb_o, 1'b1);
      chk("to_wait_err", wbm_err_o, 2'b00);
    end
    tick(); #1;
    chk("to_err", wbm_err_o, 2'b01);
    chk("to_pulse", timeout_o, 1'b1);
    chk("to_stb_masked", wbs_stb_o, 1'b0);
    chk("to_cyc_masked", wbs_cyc_o, 1'b0);
    chk("to_no_ack", wbm_ack_o, 2'b00);
    tick();
    req(0, 1'b0, 32'h0, 3'b000, 1'b0);
    #1;
    chk("to_pulse_end", timeout_o, 1'b0);
    tick();

    // Slave ack coinciding with the timeout cycle
    tick();
    req(0, 1'b1, 32'h5000_0004, 3'b000, 1'b0);
    for (int w = 1; w <= 4; w++) tick();
    tick();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    #1;
    chk("co_ack", wbm_ack_o, 2'b01);
    chk("co_err", wbm_err_o, 2'b00);
    chk("co_timeout", timeout_o, 1'b0);
    chk("co_stb", wbs_stb_o, 1'b1);
    tick();
    s_ack = 1'b0; s_dat = '0;
    req(0, 1'b0, 32'h0, 3'b000, 1'b0);
    tick();

    // Reset while m1 owns the bus
    tick();
    req(1, 1'b1, 32'h6000_0000, 3'b000, 1'b0);
    tick(); #1;
    chk("rm_m1_grant", grant_o, 2'b10);
    rst = 1'b1;
    req(0, 1'b1, 32'h7000_0000, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_grant", grant_o, 2'b00);
    chk("rm_cyc", wbs_cyc_o, 1'b0);
    chk("rm_stb", wbs_stb_o, 1'b0);
    chk("rm_adr", wbs_adr_o, 32'h0);
    chk("rm_ack", wbm_ack_o, 2'b00);
    tick(); #1;
    chk("rm_m0_wins", grant_o, 2'b01);
    // Reset again while m0 owns: last_owner must return to m1's index
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm2_grant", grant_o, 2'b00);
    tick(); #1;
    chk("rm2_m0_wins", grant_o, 2'b01);
    req(0, 1'b0, 32'h0, 3'b000, 1'b0);
    req(1, 1'b0, 32'h0, 3'b000, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
